// File: rtl/uart_rx.sv
// UART receiver: 2-flop input sync, mid-bit sampling, LSB-first shift, stop check.
// Optional parity (PARITY state, parity_err_o, PARITY_ODD) with `define UART_RX_PARITY_EN.
module uart_rx #(
    parameter int CLKS_PER_BIT = 10416,
`ifdef UART_RX_PARITY_EN
    parameter int PARITY_ODD   = 0,
`endif
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 byte_ready_o,
    output logic                 framing_err_o,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_err_o,
`endif
    output logic                 busy_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 r_state;
    logic                   r_rx_meta;
    logic                   r_rx_s;
    logic [CW-1:0]          r_cnt;
    logic [IW-1:0]          r_idx;
    logic [DATA_BITS-1:0]   r_shift;
    logic [DATA_BITS-1:0]   r_data;
    logic                   r_ready;
    logic                   r_ferr;
    logic                   r_busy;
    logic                   w_par_bad;

`ifdef UART_RX_PARITY_EN
    logic                   r_par_bit;
    logic                   r_perr;
    logic                   w_par_exp;

    assign w_par_exp    = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_par_bad    = (w_par_exp != r_par_bit);
    assign parity_err_o = r_perr;
`else
    assign w_par_bad    = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
            r_busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bit <= 1'b0;
            r_perr    <= 1'b0;
`endif
        end else begin
            r_ready <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
            r_busy  <= (r_state != S_IDLE);
            r_cnt   <= r_cnt + 1'b1;
            unique case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) r_state <= S_START;
                end
                S_START: begin
                    if (r_cnt == CNT_MID) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // a high line at mid-start is a glitch, not a frame
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt     <= '0;
                        r_par_bit <= r_rx_s;
                        r_state   <= S_STOP;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == CNT_LAST) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_ferr  <= 1'b1;
                            r_state <= S_BREAK;
                        end else begin
                            r_state <= S_IDLE;
                            if (w_par_bad) begin
`ifdef UART_RX_PARITY_EN
                                r_perr <= 1'b1;
`endif
                            end else begin
                                r_data  <= r_shift;
                                r_ready <= 1'b1;
                            end
                        end
                    end
                end
                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_s) r_state <= S_IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_o        = r_data;
    assign byte_ready_o  = r_ready;
    assign framing_err_o = r_ferr;
    assign busy_o        = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx with CLKS_PER_BIT=16, DATA_BITS=8.
// Parity cases run only when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       ferr;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       perr;
`else
    logic       perr = 1'b0;
`endif

    int n_chk = 0;
    int n_err = 0;

    int ready_cnt = 0;
    int ferr_cnt = 0;
    int perr_cnt = 0;
    int busy_run = 0;
    int busy_max = 0;
    logic both_seen = 1'b0;
    logic long_pulse = 1'b0;
    logic prev_pulse = 1'b0;
    logic [7:0] got_q[$];

    always #5 clk = ~clk;

    uart_rx #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (8)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .rx_i          (rx),
        .data_o        (data),
        .byte_ready_o  (ready),
        .framing_err_o (ferr),
`ifdef UART_RX_PARITY_EN
        .parity_err_o  (perr),
`endif
        .busy_o        (busy)
    );

    always @(posedge clk) begin
        #1;
        if (ready) begin
            ready_cnt++;
            got_q.push_back(data);
        end
        if (ferr) ferr_cnt++;
        if (perr) perr_cnt++;
        if ((ready && ferr) || (ready && perr) || (ferr && perr))
            both_seen = 1'b1;
        if (prev_pulse && (ready || ferr || perr))
            long_pulse = 1'b1;
        prev_pulse = ready || ferr || perr;
        busy_run = busy ? busy_run + 1 : 0;
        if (busy_run > busy_max) busy_max = busy_run;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic use_par,
                              input logic par, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (use_par) send_bit(par);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    int r0, f0;

    initial begin
        repeat (4) @(negedge clk);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_ferr", 32'(ferr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_perr", 32'(perr), 0);
        reset = 1'b0;
        idle(10);

        // 0xA5 good frame
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("a5_ready_cnt", ready_cnt, 1);
        chk("a5_data", 32'(data), 32'hA5);
        chk("a5_ferr_cnt", ferr_cnt, 0);
        chk("a5_busy_idle", 32'(busy), 0);

        // 4-cycle low glitch
        r0 = ready_cnt;
        f0 = ferr_cnt;
        busy_max = 0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        idle(40);
        chk("gl_ready", ready_cnt - r0, 0);
        chk("gl_ferr", ferr_cnt - f0, 0);
        chk("gl_data", 32'(data), 32'hA5);
        chk("gl_busy_seen", 32'(busy_max > 0), 1);
        chk("gl_busy_max", 32'(busy_max <= 10), 1);
        chk("gl_busy_end", 32'(busy), 0);

        // 0x3C with low stop, line held low
        r0 = ready_cnt;
        f0 = ferr_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(1'(8'h3C >> i));
        rx = 1'b0;
        repeat (CPB + 50) @(negedge clk);
        chk("fe_pulse", ferr_cnt - f0, 1);
        chk("fe_ready", ready_cnt - r0, 0);
        chk("fe_data", 32'(data), 32'hA5);
        chk("fe_busy_low", 32'(busy), 1);
        idle(10);
        chk("fe_busy_rel", 32'(busy), 0);
        chk("fe_no_restart", ferr_cnt - f0, 1);

        // back-to-back 0x00, 0xFF
        r0 = ready_cnt;
        got_q.delete();
        send_frame(8'h00, 1'b0, 1'b0, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("bb_pulses", ready_cnt - r0, 2);
        chk("bb_first", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, 32'h00);
        chk("bb_second", (got_q.size() > 1) ? 32'(got_q[1]) : 32'hDEAD, 32'hFF);
        chk("bb_data", 32'(data), 32'hFF);

        // reset mid-frame during 4th data bit of 0xFF
        r0 = ready_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mr_data", 32'(data), 32'h00);
        chk("mr_busy", 32'(busy), 0);
        chk("mr_ready", 32'(ready), 0);
        idle(CPB * 6);
        chk("mr_no_pulse", ready_cnt - r0, 0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1);
        idle(20);
        chk("mr_5a_pulse", ready_cnt - r0, 1);
        chk("mr_5a_data", 32'(data), 32'h5A);

`ifdef UART_RX_PARITY_EN
        r0 = ready_cnt;
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        idle(20);
        chk("par_ok_pulse", ready_cnt - r0, 1);
        chk("par_ok_data", 32'(data), 32'h81);
        chk("par_ok_perr", perr_cnt, 0);
        r0 = ready_cnt;
        send_frame(8'h81, 1'b1, 1'b1, 1'b1);
        idle(20);
        chk("par_bad_perr", perr_cnt, 1);
        chk("par_bad_ready", ready_cnt - r0, 0);
        chk("par_bad_data", 32'(data), 32'h81);
`endif

        chk("excl_pulses", 32'(both_seen), 0);
        chk("one_cycle", 32'(long_pulse), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
